// File: rtl/la_iodir_if.sv
// Link-direction control bundle between the padring sequencer and its requester.
// Carries the direction request and the registered steering/enable status back.
interface la_iodir_if;
  localparam int unsigned NSW_W = 8;

  logic             dir_in;
  logic             busy;
  logic             a2b;
  logic             oe_a;
  logic             oe_b;
  logic             turn;
  logic [NSW_W-1:0] nswitch;
  logic             timeout;

  modport master (
    output dir_in, busy,
    input  a2b, oe_a, oe_b, turn, nswitch, timeout
  );

  modport slave (
    input  dir_in, busy,
    output a2b, oe_a, oe_b, turn, nswitch, timeout
  );
endinterface

// File: rtl/la_iodir.sv
// Break-before-make direction sequencer for a shared A<->B link (drain, fixed gap, drive).
// Optional drain timeout compiled in with LA_IODIR_TIMEOUT_EN.
module la_iodir #(
  parameter int unsigned TURN    = 2,
  parameter bit          DIRRST  = 1'b0,
  parameter int unsigned TIMEOUT = 16
) (
  input logic       clk,
  input logic       nreset,
  la_iodir_if.slave io
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NSW_W  = 8;
  localparam int unsigned DCNT_W = 8;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(TURN - 1);

  if ((TURN < 1) || (TURN > 15)) begin : g_bad_turn
    $error("la_iodir: TURN must be 1..15");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("la_iodir: TIMEOUT must be 1..255");
  end

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_DRV   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a2b_q, a2b_d;
  logic             oe_a_q, oe_a_d;
  logic             oe_b_q, oe_b_d;
  logic             turn_q, turn_d;
  logic [NSW_W-1:0] nsw_q, nsw_d;
  logic             timeout_q, timeout_d;
  logic             first_q, first_d;
  logic             force_c;

`ifdef LA_IODIR_TIMEOUT_EN
  localparam int unsigned DW1 = DCNT_W + 1;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  // Forced drain fires on the busy cycle that would bring the drain count to TIMEOUT.
  assign force_c = io.busy && ((DW1'(dcnt_q) + DW1'(1)) == DW1'(TIMEOUT));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) dcnt_q <= '0;
    else         dcnt_q <= dcnt_d;
  end
`else
  assign force_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_GAP;
      cnt_q     <= GAP_LOAD;
      a2b_q     <= DIRRST;
      oe_a_q    <= 1'b0;
      oe_b_q    <= 1'b0;
      turn_q    <= 1'b1;
      nsw_q     <= '0;
      timeout_q <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a2b_q     <= a2b_d;
      oe_a_q    <= oe_a_d;
      oe_b_q    <= oe_b_d;
      turn_q    <= turn_d;
      nsw_q     <= nsw_d;
      timeout_q <= timeout_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a2b_d     = a2b_q;
    oe_a_d    = oe_a_q;
    oe_b_d    = oe_b_q;
    turn_d    = turn_q;
    nsw_d     = nsw_q;
    timeout_d = 1'b0;
    first_d   = first_q;
`ifdef LA_IODIR_TIMEOUT_EN
    dcnt_d    = dcnt_q;
`endif

    unique case (state_q)
      ST_DRV: begin
        oe_a_d = a2b_q;
        oe_b_d = ~a2b_q;
        turn_d = 1'b0;
        if (io.dir_in != a2b_q) begin
          state_d = ST_DRAIN;
`ifdef LA_IODIR_TIMEOUT_EN
          dcnt_d  = '0;
`endif
        end
      end

      // Current side keeps driving until its transfer finishes or the request reverts.
      ST_DRAIN: begin
        if (io.dir_in == a2b_q) begin
          state_d = ST_DRV;
`ifdef LA_IODIR_TIMEOUT_EN
          dcnt_d  = '0;
`endif
        end else if (!io.busy || force_c) begin
          state_d   = ST_GAP;
          oe_a_d    = 1'b0;
          oe_b_d    = 1'b0;
          turn_d    = 1'b1;
          cnt_d     = GAP_LOAD;
          timeout_d = force_c;
`ifdef LA_IODIR_TIMEOUT_EN
          dcnt_d    = '0;
`endif
        end else begin
`ifdef LA_IODIR_TIMEOUT_EN
          dcnt_d = dcnt_q + DCNT_W'(1);
`endif
        end
      end

      // Fixed gap with both enables low; the first gap after reset keeps DIRRST.
      ST_GAP: begin
        oe_a_d = 1'b0;
        oe_b_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_DRV;
          turn_d  = 1'b0;
          first_d = 1'b0;
          if (!first_q) begin
            a2b_d = ~a2b_q;
            if (nsw_q != '1) nsw_d = nsw_q + NSW_W'(1);
          end
          oe_a_d = a2b_d;
          oe_b_d = ~a2b_d;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
        oe_a_d  = 1'b0;
        oe_b_d  = 1'b0;
        turn_d  = 1'b1;
      end
    endcase
  end

  assign io.a2b     = a2b_q;
  assign io.oe_a    = oe_a_q;
  assign io.oe_b    = oe_b_q;
  assign io.turn    = turn_q;
  assign io.nswitch = nsw_q;
  assign io.timeout = timeout_q;

endmodule
